// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types for the parameterised register file
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - clear-sweep FSM and index counter for the register file
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          r_i,
  input  logic          clr_req_i,
  output logic [AW-1:0] index_o,
  output logic          sweep_we_o,
  output logic          clr_busy_o,
  output logic          clr_done_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] index_q, index_d;

  always_ff @(posedge clk_i) begin
    if (r_i) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = SWEEP;
          index_d = '0;
        end
      end
      SWEEP: begin
        index_d = index_q + AW'(1);
        if (index_q == LAST) begin
          state_d = DONE;
          index_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign index_o    = index_q;
  assign sweep_we_o = (state_q == SWEEP);
  assign clr_busy_o = (state_q != IDLE);
  assign clr_done_o = (state_q == DONE);

endmodule

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - two-read one-write register file with clear sweep
module param_register_file
  import regfile_pkg::*;
#(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          R,
  input  logic          En,
  input  logic [AW-1:0] WAddr,
  input  logic [N-1:0]  D,
  input  logic [AW-1:0] RAddrA,
  input  logic [AW-1:0] RAddrB,
  input  logic          ClrReq,
  output logic [N-1:0]  QA,
  output logic [N-1:0]  QB,
  output logic          ClrBusy,
  output logic          ClrDone
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  qa_q, qb_q;
  logic [N-1:0]  q_d [2];
  logic [AW-1:0] raddr [2];
  logic [AW-1:0] sweep_idx;
  logic          sweep_we;
  logic          user_we;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk_i      (Clk),
    .r_i        (R),
    .clr_req_i  (ClrReq),
    .index_o    (sweep_idx),
    .sweep_we_o (sweep_we),
    .clr_busy_o (ClrBusy),
    .clr_done_o (ClrDone)
  );

  assign user_we  = En && !ClrBusy && ({1'b0, WAddr} < DEPTH_W) &&
                    !((ZERO_REG != 0) && (WAddr == '0));
  assign raddr[0] = RAddrA;
  assign raddr[1] = RAddrB;

  // Write-first read: a same-cycle write to the read address wins over the array;
  // out-of-range addresses match no entry and read 0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_d[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr[p] == AW'(i)) q_d[p] = mem_q[i];
      end
      if (user_we && (WAddr == raddr[p])) q_d[p] = D;
      if (sweep_we && (sweep_idx == raddr[p])) q_d[p] = '0;
      if ((ZERO_REG != 0) && (raddr[p] == '0)) q_d[p] = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      qa_q <= '0;
      qb_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (user_we && (WAddr == AW'(i))) mem_q[i] <= D;
        else if (sweep_we && (sweep_idx == AW'(i))) mem_q[i] <= '0;
      end
      qa_q <= q_d[0];
      qb_q <= q_d[1];
    end
  end

  assign QA = qa_q;
  assign QB = qb_q;

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - bench for param_register_file (three configurations)
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        i_r, i_en, i_clr;
  logic [4:0]  i_wa, i_ra, i_rb;
  logic [31:0] i_d;

  logic [31:0] qa0, qb0, qa1, qb1;
  logic [7:0]  qa2, qb2;
  logic        busy0, done0, busy1, done1, busy2, done2;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  param_register_file u0 (
    .Clk(clk), .R(i_r), .En(i_en), .WAddr(i_wa), .D(i_d), .RAddrA(i_ra), .RAddrB(i_rb),
    .ClrReq(i_clr), .QA(qa0), .QB(qb0), .ClrBusy(busy0), .ClrDone(done0));

  param_register_file #(.ZERO_REG(0)) u1 (
    .Clk(clk), .R(i_r), .En(i_en), .WAddr(i_wa), .D(i_d), .RAddrA(i_ra), .RAddrB(i_rb),
    .ClrReq(i_clr), .QA(qa1), .QB(qb1), .ClrBusy(busy1), .ClrDone(done1));

  param_register_file #(.N(8), .DEPTH(12)) u2 (
    .Clk(clk), .R(i_r), .En(i_en), .WAddr(i_wa[3:0]), .D(i_d[7:0]), .RAddrA(i_ra[3:0]),
    .RAddrB(i_rb[3:0]), .ClrReq(i_clr), .QA(qa2), .QB(qb2), .ClrBusy(busy2), .ClrDone(done2));

  // Reference model: plain arrays; a sweep is tracked only by its age in cycles.
  int          dep   [3] = '{32, 32, 12};
  bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
  int          amask [3] = '{31, 31, 15};
  logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] mm    [3][32];
  logic [31:0] eqa [3], eqb [3];
  int          age [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(int k, int ra, bit uw, int wa, logic [31:0] dv, bit sw);
    if (ra >= dep[k] || (zr[k] && ra == 0)) return 32'h0;
    if (sw && age[k] == ra) return 32'h0;
    if (uw && wa == ra) return dv;
    return mm[k][ra];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int wa, ra, rb;
      bit uw, sw;
      logic [31:0] dv;
      if (i_r) begin
        for (int j = 0; j < 32; j++) mm[k][j] = 32'h0;
        eqa[k] = 32'h0;
        eqb[k] = 32'h0;
        age[k] = -1;
      end else begin
        wa = int'(i_wa) & amask[k];
        ra = int'(i_ra) & amask[k];
        rb = int'(i_rb) & amask[k];
        dv = i_d & dmask[k];
        uw = i_en && (age[k] < 0) && (wa < dep[k]) && !(zr[k] && wa == 0);
        sw = (age[k] >= 0) && (age[k] < dep[k]);
        eqa[k] = mread(k, ra, uw, wa, dv, sw);
        eqb[k] = mread(k, rb, uw, wa, dv, sw);
        if (uw) mm[k][wa] = dv;
        if (sw) mm[k][age[k]] = 32'h0;
        if (age[k] < 0) begin
          if (i_clr) age[k] = 0;
        end else if (age[k] == dep[k]) begin
          age[k] = -1;
        end else begin
          age[k]++;
        end
      end
    end
  endtask

  task automatic step();
    logic [31:0] aqa [3], aqb [3];
    logic        abusy [3], adone [3];
    model_edge();
    @(posedge clk);
    #1;
    aqa = '{qa0, qa1, {24'h0, qa2}};
    aqb = '{qb0, qb1, {24'h0, qb2}};
    abusy = '{busy0, busy1, busy2};
    adone = '{done0, done1, done2};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("qa%0d", k), aqa[k], eqa[k]);
      chk($sformatf("qb%0d", k), aqb[k], eqb[k]);
      chk($sformatf("busy%0d", k), {31'h0, abusy[k]}, {31'h0, age[k] >= 0});
      chk($sformatf("done%0d", k), {31'h0, adone[k]}, {31'h0, age[k] == dep[k]});
    end
  endtask

  task automatic set_in(bit r, bit en, int wa, logic [31:0] d, int ra, int rb, bit clr);
    i_r = r; i_en = en; i_wa = 5'(wa); i_d = d; i_ra = 5'(ra); i_rb = 5'(rb); i_clr = clr;
  endtask

  typedef struct {
    bit          r, en;
    int          wa;
    logic [31:0] d;
    int          ra, rb;
    logic [31:0] qa0, qb0, qa1, qa2;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int bc0, bc2, dc0, dc2;

    tbl[0] = '{1'b1, 1'b0,  0, 32'h0,         0,  0, 32'h0,         32'h0,         32'h0,         32'h0};
    tbl[1] = '{1'b0, 1'b1,  5, 32'hDEADBEEF,  5,  0, 32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  32'hEF};
    tbl[2] = '{1'b0, 1'b0,  0, 32'h0,         0,  5, 32'h0,         32'hDEADBEEF,  32'h0,         32'h0};
    tbl[3] = '{1'b0, 1'b1,  0, 32'h7,         0,  0, 32'h0,         32'h0,         32'h7,         32'h0};
    tbl[4] = '{1'b0, 1'b0,  0, 32'h0,         0,  5, 32'h0,         32'hDEADBEEF,  32'h7,         32'h0};
    tbl[5] = '{1'b0, 1'b1, 31, 32'hA5A5A5A5, 31, 31, 32'hA5A5A5A5,  32'hA5A5A5A5,  32'hA5A5A5A5,  32'h0};
    tbl[6] = '{1'b0, 1'b1, 13, 32'h12345678, 13,  5, 32'h12345678,  32'hDEADBEEF,  32'h12345678,  32'h0};

    set_in(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) age[k] = -1;

    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].r, tbl[v].en, tbl[v].wa, tbl[v].d, tbl[v].ra, tbl[v].rb, 1'b0);
      step();
      chk($sformatf("tbl%0d_qa0", v), qa0, tbl[v].qa0);
      chk($sformatf("tbl%0d_qb0", v), qb0, tbl[v].qb0);
      chk($sformatf("tbl%0d_qa1", v), qa1, tbl[v].qa1);
      chk($sformatf("tbl%0d_qa2", v), {24'h0, qa2}, tbl[v].qa2);
    end

    // Reset, then sweep every address on both ports.
    set_in(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0);
    step();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b0, 0, 32'h0, a, 31 - a, 1'b0);
      step();
    end

    // Fill with index, then a full clear sweep with a dropped mid-sweep write.
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b1, a, 32'(a), a, 0, 1'b0);
      step();
    end
    bc0 = 0; bc2 = 0; dc0 = 0; dc2 = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 6) set_in(1'b0, 1'b1, 9, 32'hFFFF, 9, 9, 1'b0);
      else        set_in(1'b0, 1'b0, 0, 32'h0, c % 32, 9, c == 0);
      step();
      bc0 += int'(busy0); bc2 += int'(busy2);
      dc0 += int'(done0); dc2 += int'(done2);
    end
    chk("sweep_busy_len0", 32'(bc0), 32'd33);
    chk("sweep_busy_len2", 32'(bc2), 32'd13);
    chk("sweep_done_cnt0", 32'(dc0), 32'd1);
    chk("sweep_done_cnt2", 32'(dc2), 32'd1);
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b0, 0, 32'h0, a, 9, 1'b0);
      step();
    end

    // Refill, start a sweep and abort it with R at sweep cycle 10.
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b1, a, $urandom, 0, 0, 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1);
    step();
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 1'b0, 0, 32'h0, 20, 3, 1'b0);
      step();
    end
    set_in(1'b1, 1'b0, 0, 32'h0, 20, 3, 1'b0);
    step();
    chk("abort_busy0", {31'h0, busy0}, 32'h0);
    dc0 = 0;
    for (int c = 0; c < 40; c++) begin
      set_in(1'b0, 1'b0, 0, 32'h0, c % 32, (c + 7) % 32, 1'b0);
      step();
      dc0 += int'(done0);
    end
    chk("abort_done_cnt0", 32'(dc0), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      set_in($urandom_range(0, 99) == 0, 1'($urandom), int'($urandom_range(0, 31)), $urandom,
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom_range(0, 29) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
